// File: rtl/pc_ras_sequencer_if.sv
// Fetch-control bundle between the front end and the PC/RAS sequencer.
// The master drives the control events, and the slave returns the fetch address and the RAS status.
interface pc_ras_sequencer_if #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall_pipeline_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_addr_i;
  logic              call_i;
  logic              return_i;
  logic [ADDR_W-1:0] program_counter_o;
  logic [CNT_W-1:0]  ras_count_o;
  logic              ras_empty_o;
  logic              ras_full_o;
  logic              ras_err_o;

  modport master (
    output stall_pipeline_i, redirect_i, redirect_addr_i, call_i, return_i,
    input  program_counter_o, ras_count_o, ras_empty_o, ras_full_o, ras_err_o
  );

  modport slave (
    input  stall_pipeline_i, redirect_i, redirect_addr_i, call_i, return_i,
    output program_counter_o, ras_count_o, ras_empty_o, ras_full_o, ras_err_o
  );
endinterface

// File: rtl/pc_ras_sequencer.sv
// Fetch program counter with a circular return-address stack.
// Redirect, stall, return, call and sequential increment are prioritised in that order.
module pc_ras_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int START_ADDR = 2,
  parameter int INC        = 2,
  parameter int RAS_DEPTH  = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  pc_ras_sequencer_if.slave  bus
);
  localparam int   PTR_W          = $clog2(RAS_DEPTH);
  localparam int   CNT_W          = PTR_W + 1;
  localparam logic STALL_PIPELINE = 1'b1;

  typedef enum logic [2:0] {
    OP_SEQ,
    OP_REDIRECT,
    OP_HOLD,
    OP_PUSH,
    OP_OVERFLOW,
    OP_POP,
    OP_UNDERFLOW,
    OP_SWAP
  } op_e;

  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  op_e               w_op;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [PTR_W-1:0]  w_ptr_plus1;
  logic [ADDR_W-1:0] w_pc_next;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_err_next;
  logic              w_ras_we;
  logic [PTR_W-1:0]  w_ras_waddr;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(RAS_DEPTH));
  assign w_pc_inc    = r_pc + ADDR_W'(INC);
  assign w_ptr_plus1 = r_ptr + PTR_W'(1);

  // A simultaneous call and return on an empty stack falls through to a plain call.
  always_comb begin
    w_op = OP_SEQ;
    if (bus.redirect_i) begin
      w_op = OP_REDIRECT;
    end else if (bus.stall_pipeline_i == STALL_PIPELINE) begin
      w_op = OP_HOLD;
    end else if (bus.return_i && bus.call_i && !w_empty) begin
      w_op = OP_SWAP;
    end else if (bus.return_i && !bus.call_i) begin
      w_op = w_empty ? OP_UNDERFLOW : OP_POP;
    end else if (bus.call_i) begin
      w_op = w_full ? OP_OVERFLOW : OP_PUSH;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_pc_next    = w_pc_inc;
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    w_err_next   = 1'b0;
    w_ras_we     = 1'b0;
    w_ras_waddr  = w_ptr_plus1;
    unique case (w_op)
      OP_REDIRECT:  w_pc_next = bus.redirect_addr_i;
      OP_HOLD:      w_pc_next = r_pc;
      OP_PUSH: begin
        w_ras_we     = 1'b1;
        w_ptr_next   = w_ptr_plus1;
        w_count_next = r_count + CNT_W'(1);
      end
      OP_OVERFLOW: begin
        w_ras_we   = 1'b1;
        w_ptr_next = w_ptr_plus1;
        w_err_next = 1'b1;
      end
      OP_POP: begin
        w_pc_next    = r_ras[r_ptr];
        w_ptr_next   = r_ptr - PTR_W'(1);
        w_count_next = r_count - CNT_W'(1);
      end
      OP_UNDERFLOW: w_err_next = 1'b1;
      OP_SWAP: begin
        w_pc_next   = r_ras[r_ptr];
        w_ras_we    = 1'b1;
        w_ras_waddr = r_ptr;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc    <= ADDR_W'(START_ADDR);
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_ptr   <= w_ptr_next;
      r_count <= w_count_next;
      r_err   <= w_err_next;
    end
  end

  // NOTE: stack storage has no reset; entries are only read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_ras_we) begin
      r_ras[w_ras_waddr] <= w_pc_inc;
    end
  end

  assign bus.program_counter_o = r_pc;
  assign bus.ras_count_o       = r_count;
  assign bus.ras_empty_o       = w_empty;
  assign bus.ras_full_o        = w_full;
  assign bus.ras_err_o         = r_err;
endmodule

// File: doc/pc_ras_sequencer.md
PC_RAS_SEQUENCER -- requirements
Module: pc_ras_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32 (WORD): width of all address ports.
REQ-002 SHALL have parameter START_ADDR, default 2: program counter value after reset.
REQ-003 SHALL have parameter INC, default 2 (Thumb halfword): sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-005 SHALL have port clk_i  in  1  clock; all state updates on posedge.
REQ-006 SHALL have port reset_i  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port stall_pipeline_i  in  stall_pipeline_sig  value STALL_PIPELINE freezes all state.
REQ-008 SHALL have port redirect_i  in  1  taken branch or exception from execute.
REQ-009 SHALL have port redirect_addr_i  in  ADDR_W  redirect target.
REQ-010 SHALL have port call_i  in  1  predicted BL at current PC; push return address.
REQ-011 SHALL have port return_i  in  1  predicted BX LR at current PC; pop target.
REQ-012 SHALL have port program_counter_o  out  ADDR_W  registered fetch address.
REQ-013 SHALL have port ras_count_o  out  $clog2(RAS_DEPTH)+1  valid entries.
REQ-014 SHALL have port ras_empty_o / ras_full_o  out  1 each  combinational from count.
REQ-015 SHALL have port ras_err_o  out  1  one-cycle registered pulse on underflow or overflow.

Function
REQ-016 SHALL register program_counter_o; a change of state is visible one cycle after the event that causes it.
REQ-017 SHALL select the next PC with this priority: reset > redirect_i > stall > return_i > call_i > sequential.
REQ-018 SHALL, on redirect_i, load redirect_addr_i and ignore call_i, return_i and stall_pipeline_i; the RAS is unchanged.
REQ-019 SHALL, when stalled and no redirect is present, hold the PC, RAS contents, count and pointer; ras_err_o = 0.
REQ-020 SHALL, on call_i only, set next PC = PC+INC, write PC+INC at top pointer+1, and increment the pointer.
REQ-021 SHALL, on call_i only while full, overwrite the oldest entry (circular wrap), keep count at RAS_DEPTH, and pulse ras_err_o.
REQ-022 SHALL, on return_i only while not empty, set next PC = top entry, decrement the pointer (mod RAS_DEPTH), and decrement count.
REQ-023 SHALL, on return_i while empty, set next PC = PC+INC, leave the RAS unchanged, and pulse ras_err_o.
REQ-024 SHALL, on call_i and return_i together while not empty, set next PC = top, overwrite top with PC+INC, and leave count and pointer unchanged.
REQ-025 SHALL, on call_i and return_i together while empty, behave as call_i only.
REQ-026 SHALL, with no event, set next PC = PC+INC, modulo 2^ADDR_W (wraps silently).
REQ-027 SHALL have no redirect-to-fetch bubble: redirect_addr_i appears on program_counter_o the cycle after redirect_i.

Reset
REQ-028 SHALL, on reset_i, set program_counter_o = START_ADDR, ras_count_o = 0, pointer = 0, ras_err_o = 0.
REQ-029 SHALL give reset_i priority over every input, including mid-stall and mid-redirect.
REQ-030 SHALL not clear RAS entry storage on reset; entries are unobservable while count is 0.
REQ-031 SHALL NOT put X on any output in the first cycle after reset deasserts.

Verification
REQ-032 Reset then 3 idle cycles -> PC 2, 4, 6, 8; ras_empty_o = 1.
REQ-033 PC=0x10: call_i; then 2 idle cycles; then return_i -> PC 0x12, 0x14, 0x16, then 0x12; count 1 then 0.
REQ-034 RAS_DEPTH=4: 5 consecutive calls from PC 0x100 -> ras_err_o pulses on the 5th; 4 returns yield 0x10A, 0x108, 0x106, 0x104.
REQ-035 Empty RAS with return_i at PC=0x20 -> PC 0x22, ras_err_o = 1 for exactly one cycle, count stays 0.
REQ-036 stall_pipeline_i held 3 cycles with call_i asserted -> PC and count frozen; redirect_i to 0x400 during the stall -> PC 0x400 the next cycle.
REQ-037 call_i and return_i together with top = 0x50 at PC 0x30 -> PC 0x50, top becomes 0x32, count unchanged; reset_i asserted mid-sequence -> PC 2, count 0 the next cycle.
